// File: rtl/fetch_decode_latch.sv
// fetch_decode_latch: pipeline register between fetch and decode.
// Holds the instruction word and its PC+2 for the decode stage, inserts
// NOP bubbles on empty fetch or taken branch, holds contents on stall and
// freezes permanently on a halt opcode until reset.
// Optional feature: define FETCH_DECODE_STALL_CNT_EN to add a saturating
// stall cycle counter on output stall_cnt.
module fetch_decode_latch #(
    parameter logic [15:0] NOP_INSTR = 16'h0800,
    parameter logic [4:0]  HALT_OPC  = 5'b00000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] instr_in,
    input  logic [15:0] pc_inc_in,
    input  logic        valid_in,
    input  logic        stall,
    input  logic        flush,
    output logic [15:0] instruction,
    output logic [15:0] pc_inc_out,
    output logic        valid_out,
    output logic        ready_out,
    output logic        halted,
    output logic        err
`ifdef FETCH_DECODE_STALL_CNT_EN
    ,
    output logic [15:0] stall_cnt
`endif
);

    localparam int DATA_W = 16;

    typedef enum logic [1:0] {
        RUN     = 2'b00,
        HOLD    = 2'b01,
        HALTED  = 2'b10,
        ILLEGAL = 2'b11
    } state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   instr_p1, instr_d;
    logic [DATA_W-1:0]   pc_p1, pc_d;
    logic                vld_p1, vld_d;
    logic                err_q, err_d;
    logic                active;

    // RUN and HOLD are the only states in which the latch accepts traffic
    assign active = (state_q == RUN) || (state_q == HOLD);

    // Accept is blocked by reset, by a frozen/illegal state, or by stall without flush
    assign ready_out = ~rst & active & (~stall | flush);

    // Next-state and next-contents decision for the latch
    always_comb begin
        state_d = state_q;
        instr_d = instr_p1;
        pc_d    = pc_p1;
        vld_d   = vld_p1;
        err_d   = err_q;
        case (state_q)
            RUN, HOLD: begin
                if (flush) begin
                    // Taken branch: discard younger instruction, keep last PC+2
                    instr_d = NOP_INSTR;
                    vld_d   = 1'b0;
                    state_d = RUN;
                end else if (stall) begin
                    state_d = HOLD;
                end else if (valid_in) begin
                    instr_d = instr_in;
                    pc_d    = pc_inc_in;
                    vld_d   = 1'b1;
                    state_d = (instr_in[15:11] == HALT_OPC) ? HALTED : RUN;
                end else begin
                    // Empty fetch slot becomes a bubble; PC+2 is left alone
                    instr_d = NOP_INSTR;
                    vld_d   = 1'b0;
                    state_d = RUN;
                end
            end
            HALTED: begin
                // Redirect while frozen is a protocol violation; contents stay put
                if (flush) err_d = 1'b1;
            end
            default: begin
                err_d   = 1'b1;
                state_d = HALTED;
            end
        endcase
    end

    // Pipeline stage p1: register state and latch contents
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= RUN;
            instr_p1 <= NOP_INSTR;
            pc_p1    <= '0;
            vld_p1   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            instr_p1 <= instr_d;
            pc_p1    <= pc_d;
            vld_p1   <= vld_d;
            err_q    <= err_d;
        end
    end

    assign instruction = instr_p1;
    assign pc_inc_out  = pc_p1;
    assign valid_out   = vld_p1;
    assign halted      = (state_q == HALTED);
    assign err         = err_q;

`ifdef FETCH_DECODE_STALL_CNT_EN
    logic [15:0] cnt_q;
    logic        stall_ev;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // A stall cycle is one where the latch is active and stall is not overridden by flush
    assign stall_ev = active & stall & ~flush;

    // Saturating count of stall cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (stall_ev) begin
            cnt_q <= sat_inc16(cnt_q);
        end
    end

    assign stall_cnt = cnt_q;
`endif

endmodule

// File: doc/fetch_decode_latch.md
FETCH_DECODE_LATCH -- requirements
Module: fetch_decode_latch

Interface
REQ-001 Parameter NOP_INSTR, default 16'h0800, instruction word inserted on reset, flush and bubble.
REQ-002 Parameter HALT_OPC, default 5'b00000, opcode (bits 15:11) that freezes the latch.
REQ-003 clk  input  1  pipeline clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 instr_in  input  16  instruction word from fetch.
REQ-006 pc_inc_in  input  16  PC+2 from fetch.
REQ-007 valid_in  input  1  fetch presents a valid instruction this cycle.
REQ-008 stall  input  1  hazard unit requests the decode contents be held.
REQ-009 flush  input  1  branch/jump resolved taken; discard the younger instruction.
REQ-010 instruction  output  16  word presented to decode.
REQ-011 pc_inc_out  output  16  PC+2 of the held instruction.
REQ-012 valid_out  output  1  instruction output is a real instruction, not a bubble.
REQ-013 ready_out  output  1  latch will accept instr_in on this edge.
REQ-014 halted  output  1  latch is frozen on a halt instruction.
REQ-015 err  output  1  sticky protocol error flag.

Function
REQ-016 States: RUN, HOLD, HALTED; encoded in 2 bits; value 2'b11 is illegal.
REQ-017 RUN, no stall/flush, valid_in=1: capture instr_in/pc_inc_in, valid_out=1 next cycle (latency 1).
REQ-018 RUN, valid_in=0: load NOP_INSTR, valid_out=0, pc_inc_out keeps its prior value.
REQ-019 stall=1 in RUN or HOLD (flush=0): hold all outputs, next state HOLD, ready_out=0 combinationally.
REQ-020 HOLD with stall=0: behave as RUN on that edge (capture or bubble) and return to RUN.
REQ-021 flush=1 outside HALTED: load NOP_INSTR, valid_out=0, next state RUN; flush overrides stall in the same cycle.
REQ-022 An edge that captures an instruction with instr_in[15:11]==HALT_OPC and valid_in=1 SHALL enter HALTED with that word on instruction and valid_out=1.
REQ-023 HALTED: outputs frozen, ready_out=0, halted=1; leaves only on rst.
REQ-024 ready_out = (state != HALTED) & ~stall & ~flush | flush&(state!=HALTED) -- i.e. accept is suppressed only by stall without flush, or by HALTED.
REQ-025 flush=1 while HALTED SHALL set err; stall=1 and flush=1 together is legal (flush wins) and does not set err.
REQ-026 Reaching the illegal state encoding SHALL set err and force HALTED.
REQ-027 err is sticky until rst.

Reset
REQ-028 On rst=1 at an edge: instruction=NOP_INSTR, pc_inc_out=16'h0000, valid_out=0, state=RUN, halted=0, err=0.
REQ-029 rst overrides stall, flush and HALTED in the same cycle; ready_out=0 while rst=1.
REQ-030 rst asserted mid-HOLD or mid-HALTED discards the held instruction; first capture is the edge after rst deasserts.

Configuration
REQ-031 Macro FETCH_DECODE_STALL_CNT_EN: when defined, add output stall_cnt [15:0], incremented on every edge where state is RUN/HOLD and stall=1 and flush=0, saturating at 16'hFFFF, cleared by rst.
REQ-032 When FETCH_DECODE_STALL_CNT_EN is undefined, no stall_cnt port and no counter logic exist; all other behaviour is identical.

Verification
REQ-033 rst=1 one cycle then rst=0, valid_in=0 -> instruction=16'h0800, valid_out=0, halted=0, err=0.
REQ-034 valid_in=1, instr_in=16'h4123, pc_inc_in=16'h0010, then stall=1 for 3 cycles with instr_in=16'h5555 -> instruction stays 16'h4123, pc_inc_out 16'h0010, ready_out=0 for 3 cycles; stall_cnt=3 if macro defined.
REQ-035 stall=1 and flush=1 same cycle with instruction=16'h4123 -> next cycle instruction=16'h0800, valid_out=0, state RUN, err=0.
REQ-036 Capture instr_in=16'h0000 valid_in=1 -> halted=1, instruction=16'h0000 held for 10 cycles regardless of instr_in; then flush=1 -> err=1 and outputs unchanged.
REQ-037 In HALTED assert rst one cycle -> halted=0, err=0, instruction=16'h0800; next edge with valid_in=1, instr_in=16'h6A01 captures 16'h6A01.
REQ-038 Macro defined, stall held 70000 cycles -> stall_cnt saturates at 16'hFFFF and does not wrap.
